ucsbece154b_hazard_ctrl: RTL and testbench

//  Parametrised hazard/forwarding unit for the 5-stage pipeline; replaces the inline hazard logic in the controller.

---
 rtl/ucsbece154b_hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ucsbece154b_hazard_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_hazard_ctrl.sv
// Hazard/forwarding unit for the 5-stage pipeline with imem/dmem wait handshake and timeout watchdog.
// Optional perf counters are enabled by defining UCSBECE154B_HAZARD_PERF_EN.
module ucsbece154b_hazard_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = 200
`ifdef UCSBECE154B_HAZARD_PERF_EN
    ,
    parameter int unsigned PERF_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D_i,
    input  logic [REG_AW-1:0] Rs2D_i,
    input  logic [REG_AW-1:0] Rs1E_i,
    input  logic [REG_AW-1:0] Rs2E_i,
    input  logic [REG_AW-1:0] RdE_i,
    input  logic [REG_AW-1:0] RdM_i,
    input  logic [REG_AW-1:0] RdW_i,
    input  logic              LoadE_i,
    input  logic              RegWriteM_i,
    input  logic              RegWriteW_i,
    input  logic              PCSrcE_i,
    input  logic              ImemReady_i,
    input  logic              DmemReqM_i,
    input  logic              DmemReady_i,
    output logic              StallF_o,
    output logic              StallD_o,
    output logic              StallE_o,
    output logic              StallM_o,
    output logic              FlushD_o,
    output logic              FlushE_o,
    output logic              FlushM_o,
    output logic              FlushW_o,
    output logic [1:0]        ForwardAE_o,
    output logic [1:0]        ForwardBE_o,
    output logic [1:0]        State_o,
    output logic              Error_o
`ifdef UCSBECE154B_HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] PerfLwStall_o,
    output logic [PERF_W-1:0] PerfIWait_o,
    output logic [PERF_W-1:0] PerfDWait_o,
    output logic [PERF_W-1:0] PerfFlush_o
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        IWAIT = 2'b01,
        DWAIT = 2'b10,
        ERR   = 2'b11
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic lw_stall, dwait, iwait, in_wait, to_hit;
    logic c_err, c_dwait, c_brwait, c_br, c_lw, c_iwait;

    assign lw_stall = LoadE_i && (RdE_i != '0) && ((Rs1D_i == RdE_i) || (Rs2D_i == RdE_i));
    assign dwait    = DmemReqM_i && !DmemReady_i;
    assign iwait    = !ImemReady_i;
    assign in_wait  = (state_q == IWAIT) || (state_q == DWAIT);
    // The watchdog wins over a same-cycle ready so a late completion cannot mask a timeout.
    assign to_hit   = in_wait && (to_cnt_q >= TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (dwait)      state_d = DWAIT;
                else if (iwait) state_d = IWAIT;
            end
            IWAIT, DWAIT: begin
                if (to_hit)     state_d = ERR;
                else if (dwait) state_d = DWAIT;
                else if (iwait) state_d = IWAIT;
                else            state_d = RUN;
            end
            default:            state_d = ERR;
        endcase
    end

    always_comb begin
        to_cnt_d = '0;
        if (in_wait && (state_d == state_q))
            to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;
    end

    always_comb begin
        c_err    = 1'b0;
        c_dwait  = 1'b0;
        c_brwait = 1'b0;
        c_br     = 1'b0;
        c_lw     = 1'b0;
        c_iwait  = 1'b0;
        if (!reset) begin
            if (state_q == ERR)           c_err    = 1'b1;
            else if (dwait)               c_dwait  = 1'b1;
            else if (PCSrcE_i && iwait)   c_brwait = 1'b1;
            else if (PCSrcE_i)            c_br     = 1'b1;
            else if (lw_stall)            c_lw     = 1'b1;
            else if (iwait)               c_iwait  = 1'b1;
        end
    end

    always_comb begin
        StallF_o = c_err || c_dwait || c_brwait || c_lw || c_iwait;
        StallD_o = c_err || c_dwait || c_brwait || c_lw;
        StallE_o = c_err || c_dwait || c_brwait;
        StallM_o = c_err || c_dwait;
        FlushD_o = c_brwait || c_br || c_iwait;
        FlushE_o = c_br || c_lw;
        FlushM_o = c_brwait;
        FlushW_o = c_err || c_dwait;
        State_o  = state_q;
        Error_o  = (state_q == ERR);
    end

    always_comb begin
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        if (!reset && (Rs1E_i != '0)) begin
            if (RegWriteM_i && (RdM_i == Rs1E_i))      ForwardAE_o = 2'b10;
            else if (RegWriteW_i && (RdW_i == Rs1E_i)) ForwardAE_o = 2'b01;
        end
        if (!reset && (Rs2E_i != '0)) begin
            if (RegWriteM_i && (RdM_i == Rs2E_i))      ForwardBE_o = 2'b10;
            else if (RegWriteW_i && (RdW_i == Rs2E_i)) ForwardBE_o = 2'b01;
        end
    end

`ifdef UCSBECE154B_HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_lw_q, perf_lw_d;
    logic [PERF_W-1:0] perf_iw_q, perf_iw_d;
    logic [PERF_W-1:0] perf_dw_q, perf_dw_d;
    logic [PERF_W-1:0] perf_fl_q, perf_fl_d;

    always_comb begin
        perf_lw_d = perf_lw_q;
        perf_iw_d = perf_iw_q;
        perf_dw_d = perf_dw_q;
        perf_fl_d = perf_fl_q;
        if (c_lw && (perf_lw_q != '1))                 perf_lw_d = perf_lw_q + 1'b1;
        if ((c_brwait || c_iwait) && (perf_iw_q != '1)) perf_iw_d = perf_iw_q + 1'b1;
        if (c_dwait && (perf_dw_q != '1))              perf_dw_d = perf_dw_q + 1'b1;
        if ((c_brwait || c_br) && (perf_fl_q != '1))   perf_fl_d = perf_fl_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_lw_q <= '0;
            perf_iw_q <= '0;
            perf_dw_q <= '0;
            perf_fl_q <= '0;
        end else begin
            perf_lw_q <= perf_lw_d;
            perf_iw_q <= perf_iw_d;
            perf_dw_q <= perf_dw_d;
            perf_fl_q <= perf_fl_d;
        end
    end

    assign PerfLwStall_o = perf_lw_q;
    assign PerfIWait_o   = perf_iw_q;
    assign PerfDWait_o   = perf_dw_q;
    assign PerfFlush_o   = perf_fl_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_hazard_ctrl.sv
// Scoreboard bench for ucsbece154b_hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_ucsbece154b_hazard_ctrl;

    localparam int unsigned TMO = 12;
    localparam logic [1:0] S_RUN = 2'b00, S_IW = 2'b01, S_DW = 2'b10, S_ERR = 2'b11;

    logic       clk, reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       LoadE, RegWriteM, RegWriteW, PCSrcE, ImemReady, DmemReq, DmemReady;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, Err;
    logic [1:0] FAE, FBE, State;

    ucsbece154b_hazard_ctrl #(.REG_AW(5), .TO_W(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
        .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW),
        .LoadE_i(LoadE), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
        .PCSrcE_i(PCSrcE), .ImemReady_i(ImemReady),
        .DmemReqM_i(DmemReq), .DmemReady_i(DmemReady),
        .StallF_o(StallF), .StallD_o(StallD), .StallE_o(StallE), .StallM_o(StallM),
        .FlushD_o(FlushD), .FlushE_o(FlushE), .FlushM_o(FlushM), .FlushW_o(FlushW),
        .ForwardAE_o(FAE), .ForwardBE_o(FBE), .State_o(State), .Error_o(Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] exp_q[$];
    string       name_q[$];
    int          compared = 0;
    int          mismatched = 0;

    // expected word: {StallF,D,E,M, FlushD,E,M,W, FwdA, FwdB, State, Error}
    function automatic logic [14:0] mk(input logic [3:0] s, input logic [3:0] f,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] st, input logic e);
        return {s, f, a, b, st, e};
    endfunction

    task automatic defaults();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        LoadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        ImemReady = 1; DmemReq = 0; DmemReady = 1;
    endtask

    task automatic step(input string nm, input logic [14:0] e);
        name_q.push_back(nm);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [14:0] e, obs;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, FAE, FBE, State, Err};
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL %s: got %b required %b (stall4 flush4 fa fb st err)", nm, obs, e);
            end
        end
    end

    initial begin
        reset = 1'b1;
        defaults();
        @(posedge clk);
        #1;
        LoadE = 1; RdE = 5; Rs1D = 5; Rs1E = 3; RdM = 3; RegWriteM = 1;
        PCSrcE = 1; DmemReq = 1; DmemReady = 0; ImemReady = 0;
        step("reset_hold", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_RUN, 1'b0));
        reset = 1'b0;

        defaults(); LoadE = 1; RdE = 5; Rs1D = 5;
        step("lw_rs1", mk(4'b1100, 4'b0100, 2'b00, 2'b00, S_RUN, 1'b0));
        defaults(); LoadE = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
        step("lw_x0", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_RUN, 1'b0));
        defaults(); LoadE = 1; RdE = 5; Rs1D = 1; Rs2D = 5;
        step("lw_rs2", mk(4'b1100, 4'b0100, 2'b00, 2'b00, S_RUN, 1'b0));
        defaults(); LoadE = 1; RdE = 6; Rs1D = 5; Rs2D = 7;
        step("lw_nomatch", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_RUN, 1'b0));

        defaults(); Rs1E = 3; Rs2E = 3; RdM = 3; RegWriteM = 1; RdW = 3; RegWriteW = 1;
        step("fwd_m", mk(4'b0000, 4'b0000, 2'b10, 2'b10, S_RUN, 1'b0));
        RegWriteM = 0;
        step("fwd_w", mk(4'b0000, 4'b0000, 2'b01, 2'b01, S_RUN, 1'b0));
        Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0; RegWriteM = 1;
        step("fwd_x0", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_RUN, 1'b0));
        defaults(); Rs1E = 4; Rs2E = 9; RdM = 9; RegWriteM = 1; RdW = 4; RegWriteW = 1;
        step("fwd_mix", mk(4'b0000, 4'b0000, 2'b01, 2'b10, S_RUN, 1'b0));

        defaults(); DmemReq = 1; DmemReady = 0;
        step("dw0", mk(4'b1111, 4'b0001, 2'b00, 2'b00, S_RUN, 1'b0));
        step("dw1", mk(4'b1111, 4'b0001, 2'b00, 2'b00, S_DW, 1'b0));
        PCSrcE = 1; LoadE = 1; RdE = 5; Rs1D = 5;
        step("dw2_ignore_br", mk(4'b1111, 4'b0001, 2'b00, 2'b00, S_DW, 1'b0));
        defaults(); DmemReq = 1; DmemReady = 1;
        step("dw_ready", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_DW, 1'b0));
        defaults();
        step("dw_run", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_RUN, 1'b0));

        PCSrcE = 1; ImemReady = 0;
        step("br_iw0", mk(4'b1110, 4'b1010, 2'b00, 2'b00, S_RUN, 1'b0));
        step("br_iw1", mk(4'b1110, 4'b1010, 2'b00, 2'b00, S_IW, 1'b0));
        ImemReady = 1;
        step("br_go", mk(4'b0000, 4'b1100, 2'b00, 2'b00, S_IW, 1'b0));
        defaults();
        step("br_done", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_RUN, 1'b0));

        LoadE = 1; RdE = 5; Rs1D = 5; ImemReady = 0;
        step("lw_over_iw", mk(4'b1100, 4'b0100, 2'b00, 2'b00, S_RUN, 1'b0));
        defaults(); ImemReady = 0;
        step("iw", mk(4'b1000, 4'b1000, 2'b00, 2'b00, S_IW, 1'b0));
        defaults();
        step("iw_ready", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_IW, 1'b0));
        step("iw_done", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_RUN, 1'b0));

        DmemReq = 1; DmemReady = 0; ImemReady = 0;
        step("di0", mk(4'b1111, 4'b0001, 2'b00, 2'b00, S_RUN, 1'b0));
        DmemReady = 1;
        step("di1", mk(4'b1000, 4'b1000, 2'b00, 2'b00, S_DW, 1'b0));
        defaults();
        step("di2", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_IW, 1'b0));
        step("di3", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_RUN, 1'b0));

        DmemReq = 1; DmemReady = 0;
        step("to_enter", mk(4'b1111, 4'b0001, 2'b00, 2'b00, S_RUN, 1'b0));
        for (int i = 1; i < TMO; i++)
            step("to_wait", mk(4'b1111, 4'b0001, 2'b00, 2'b00, S_DW, 1'b0));
        DmemReady = 1;
        step("to_last_ready", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_DW, 1'b0));
        defaults();
        step("err0", mk(4'b1111, 4'b0001, 2'b00, 2'b00, S_ERR, 1'b1));
        step("err1", mk(4'b1111, 4'b0001, 2'b00, 2'b00, S_ERR, 1'b1));
        Rs1E = 3; RdM = 3; RegWriteM = 1;
        step("err_fwd", mk(4'b1111, 4'b0001, 2'b10, 2'b00, S_ERR, 1'b1));
        reset = 1'b1;
        step("async_rst", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_RUN, 1'b0));
        reset = 1'b0;
        defaults();
        step("post_rst", mk(4'b0000, 4'b0000, 2'b00, 2'b00, S_RUN, 1'b0));

        repeat (3) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
